trg_pattern_gen: RTL and testbench
==================================

// Module: trg_pattern_gen
// PURPOSE
//  Parametrised successor to the jtagcom TRG_RATE / RTRG_TGL / Burst_triggers test-trigger path.
//  - Three sources: periodic, pseudo-random (LFSR threshold), and counted burst.
//  - Outputs a 1-cycle trigger plus an NCH-wide round-robin LCT pattern; feeds trgcntrl BGTRG/BSTRIP in test mode.
//  - Configuration arrives from JTAG user-register outputs already synchronised to CLKCMS.
// PARAMETERS
//  NCH       6          number of LCT channels (CFEBs)
//  PW        16         width of PERIOD
//  LW        16         LFSR width; random compare width
//  BW        8          width of BURST_N
//  CW        24         width of TRG_CNT
//  LFSR_SEED 16'hACE1   LFSR reset value; must be nonzero
//  DEADTIME  4          cycles blocked after each trigger (only with TRG_DEADTIME_EN)
// PORTS
//  CLKCMS    in   1    40 MHz CMS clock
//  RST       in   1    asynchronous, active-high reset
//  MODE      in   2    0 = off, 1 = periodic, 2 = random (trg_mode_t)
//  PERIOD    in   PW   periodic interval in cycles; 0 is treated as 1
//  THRESH    in   LW   random mode: trigger when lfsr < THRESH
//  RTRG_TGL  in   1    toggles RUN on its rising edge
//  BURST_N   in   BW   number of triggers per burst
//  BURST_GO  in   1    starts a burst on its rising edge
//  LCT_MASK  in   NCH  channels eligible for the LCT pattern
//  CNT_CLR   in   1    synchronous clear of TRG_CNT
//  TRG       out  1    registered 1-cycle trigger pulse
//  LCT       out  NCH  one-hot channel, valid only with TRG
//  RUN       out  1    periodic/random generation enabled
//  BUSY      out  1    burst in progress
//  TRG_CNT   out  CW   saturating count of emitted triggers
// BEHAVIOUR
//  - Reset: TRG=0, LCT=0, RUN=0, BUSY=0, TRG_CNT=0, period counter=0, lfsr=LFSR_SEED, channel pointer=0.
//  - Edge detect: RTRG_TGL and BURST_GO are edge-detected internally. A held level acts only once.
//  - Latency: a source decision made in cycle n produces TRG=1 in cycle n+1.
//  - RUN:
//    - Each RTRG_TGL edge inverts RUN.
//    - RUN falling: no periodic or random TRG after the next cycle; the period counter clears to 0.
//  - Periodic mode (MODE=1, RUN=1):
//    - The counter increments every cycle and fires when it reaches max(PERIOD,1)-1, then wraps to 0.
//    - First TRG occurs max(PERIOD,1) cycles after RUN rises.
//  - Random mode (MODE=2, RUN=1):
//    - The Galois LFSR steps every cycle while RUN=1; fire when lfsr < THRESH.
//    - THRESH=0 never fires.
//  - MODE changes: any change of MODE clears the period counter. MODE=0 or 3 never fires.
//  - Burst:
//    - A BURST_GO edge with BUSY=0 and BURST_N!=0 loads the remaining count and sets BUSY the next cycle.
//    - One trigger fires per eligible cycle. BUSY clears in the cycle the last TRG is driven.
//    - A BURST_GO edge while BUSY=1 is ignored. BURST_N=0 is ignored.
//    - Burst runs regardless of RUN.
//  - Priority: while BUSY=1, periodic and random fires are dropped (not queued); the period counter keeps counting.
//  - LCT pattern:
//    - On each TRG, LCT is the one-hot of the pointer.
//    - The pointer then advances to the next set bit of LCT_MASK above it, wrapping from NCH-1 to 0.
//    - If the pointer bit is not set in the current mask, the lowest set bit is used.
//    - LCT_MASK=0: TRG still fires with LCT=0.
//  - TRG_CNT:
//    - Increments on each TRG and saturates at all-ones.
//    - CNT_CLR wins over a simultaneous increment (result 0).
//  - Reset mid-burst: everything returns to reset values; a burst is not resumed.
// CONFIGURATION
//  - TRG_DEADTIME_EN defined:
//    - After each TRG, all sources are blocked for DEADTIME cycles.
//    - Burst triggers are spaced DEADTIME+1 cycles apart.
//    - Periodic and random fires during deadtime are dropped. The period counter and LFSR keep running.
//  - TRG_DEADTIME_EN undefined: no blocking; burst triggers occur on consecutive cycles.
// STRUCTURE
//  - Package trg_gen_pkg:
//    - trg_mode_t enum (TRG_OFF, TRG_PERIODIC, TRG_RANDOM, TRG_RSVD)
//    - LFSR tap constants per LW (16, 24, 32)
//    - default LFSR_SEED
//  - Sub-module trg_lfsr: Galois LFSR with parameters LW and SEED, inputs en and load, output state.
//  - Top level: edge detectors, period counter, burst counter/FSM (IDLE, BURST), deadtime counter, round-robin pointer, TRG_CNT.
// TESTING
//  1. Periodic: MODE=1, PERIOD=10, RTRG_TGL edge -> TRG every 10 cycles, first 10 cycles after RUN rises; 2nd RTRG_TGL edge -> TRG stops.
//  2. Burst: BURST_N=5, LCT_MASK=6'b101001, BURST_GO -> 5 consecutive TRG; LCT sequence 01,08,20,01,08 (hex); BUSY high exactly 5 cycles; TRG_CNT=5.
//  3. Random: MODE=2, THRESH=16'h4000, 40000 cycles -> ~25% duty (±2%); THRESH=0 gives no TRG.
//  4. Collision: BURST_GO edge while BUSY=1 -> ignored; periodic PERIOD=2 during burst -> no extra TRG.
//  5. Reset mid-burst: RST during 3rd of 8 burst triggers -> all outputs 0, no further TRG after release.
//  6. TRG_DEADTIME_EN with DEADTIME=4: BURST_N=3 -> TRG at cycles t, t+5, t+10; CW=4 saturation -> TRG_CNT holds at 15.

Source files
------------

// File: rtl/trg_gen_pkg.sv
// Shared types and constants for the test-trigger pattern generator:
// mode encoding, burst FSM states, Galois LFSR tap masks and the default seed.
package trg_gen_pkg;

    typedef enum logic [1:0] {
        TRG_OFF      = 2'd0,
        TRG_PERIODIC = 2'd1,
        TRG_RANDOM   = 2'd2,
        TRG_RSVD     = 2'd3
    } trg_mode_t;

    typedef enum logic {
        BST_IDLE  = 1'b0,
        BST_BURST = 1'b1
    } bst_state_t;

    // Right-shift Galois feedback masks for maximal-length sequences
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [23:0] LFSR_TAPS_24 = 24'hE1_0000;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

    function automatic logic [31:0] lfsr_taps(input int unsigned lw);
        case (lw)
            16:      return {16'h0000, LFSR_TAPS_16};
            24:      return {8'h00, LFSR_TAPS_24};
            default: return LFSR_TAPS_32;
        endcase
    endfunction

endpackage

// File: rtl/trg_lfsr.sv
// Galois LFSR used as the random-mode trigger source; steps once per cycle
// while en is high, load reseeds to SEED.
module trg_lfsr
    import trg_gen_pkg::*;
#(
    parameter int unsigned   LW   = 16,
    parameter logic [LW-1:0] SEED = LW'(DEF_LFSR_SEED)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    output logic [LW-1:0] state
);

    localparam logic [LW-1:0] TAPS = LW'(lfsr_taps(LW));

    logic [LW-1:0] state_q;
    logic [LW-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (en) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/trg_pattern_gen.sv
// Test-trigger generator: periodic, LFSR-random and counted-burst sources with a
// round-robin LCT pattern. Optional post-trigger blocking via TRG_DEADTIME_EN.
module trg_pattern_gen
    import trg_gen_pkg::*;
#(
    parameter int unsigned   NCH       = 6,
    parameter int unsigned   PW        = 16,
    parameter int unsigned   LW        = 16,
    parameter int unsigned   BW        = 8,
    parameter int unsigned   CW        = 24,
    parameter logic [LW-1:0] LFSR_SEED = LW'(DEF_LFSR_SEED),
    parameter int unsigned   DEADTIME  = 4
) (
    input  logic           CLKCMS,
    input  logic           RST,
    input  logic [1:0]     MODE,
    input  logic [PW-1:0]  PERIOD,
    input  logic [LW-1:0]  THRESH,
    input  logic           RTRG_TGL,
    input  logic [BW-1:0]  BURST_N,
    input  logic           BURST_GO,
    input  logic [NCH-1:0] LCT_MASK,
    input  logic           CNT_CLR,
    output logic           TRG,
    output logic [NCH-1:0] LCT,
    output logic           RUN,
    output logic           BUSY,
    output logic [CW-1:0]  TRG_CNT
);

    localparam int unsigned PTRW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned DW   = $clog2(DEADTIME + 2);
`ifdef TRG_DEADTIME_EN
    localparam int unsigned DEAD_CYC = DEADTIME;
`else
    localparam int unsigned DEAD_CYC = 0;
`endif

    trg_mode_t     mode;
    trg_mode_t     mode_q;
    bst_state_t    state_q, state_d;
    logic          tgl_q, go_q, run_q, run_d, trg_q, trg_d;
    logic [PW-1:0] pcnt_q, pcnt_d, plim;
    logic [BW-1:0] rem_q, rem_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [PTRW-1:0] ptr_q, ptr_d, sel, nxt, low_idx, above_idx;
    logic [NCH-1:0]  lct_q, lct_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   lfsr_state;
    logic tgl_rise, go_rise, mode_chg, per_hit, rnd_hit, dead_blk, bst_fire, fire;
    logic cur_ok, low_ok, above_ok;

    trg_lfsr #(
        .LW   (LW),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (CLKCMS),
        .rst   (RST),
        .en    (run_q),
        .load  (1'b0),
        .state (lfsr_state)
    );

    always_comb begin
        mode     = trg_mode_t'(MODE);
        tgl_rise = RTRG_TGL & ~tgl_q;
        go_rise  = BURST_GO & ~go_q;
        run_d    = run_q ^ tgl_rise;
        mode_chg = (mode != mode_q);
        plim     = (PERIOD == '0) ? '0 : PERIOD - PW'(1);
        per_hit  = run_q && (mode == TRG_PERIODIC) && (pcnt_q == plim);
        rnd_hit  = run_q && (mode == TRG_RANDOM) && (lfsr_state < THRESH);
        dead_blk = (dead_q != '0);
        bst_fire = (state_q == BST_BURST) && !dead_blk;
        // Burst owns the trigger slot; periodic/random hits are simply lost
        fire     = bst_fire ||
                   ((state_q == BST_IDLE) && !dead_blk && (per_hit || rnd_hit));

        pcnt_d = '0;
        if (run_q && (mode == TRG_PERIODIC) && !mode_chg && (pcnt_q < plim)) begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            BST_IDLE: begin
                if (go_rise && (BURST_N != '0)) begin
                    state_d = BST_BURST;
                    rem_d   = BURST_N;
                end
            end
            BST_BURST: begin
                if (bst_fire) begin
                    rem_d = rem_q - BW'(1);
                    if (rem_q == BW'(1)) begin
                        state_d = BST_IDLE;
                    end
                end
            end
            default: state_d = BST_IDLE;
        endcase
    end

    always_comb begin
        trg_d  = fire;
        dead_d = '0;
        if (fire) begin
            dead_d = DW'(DEAD_CYC);
        end else if (dead_blk) begin
            dead_d = dead_q - DW'(1);
        end

        cnt_d = cnt_q;
        if (CNT_CLR) begin
            cnt_d = '0;
        end else if (fire && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Pointer falls back to the lowest enabled channel when its own bit is masked
    always_comb begin
        cur_ok    = 1'b0;
        low_ok    = 1'b0;
        low_idx   = '0;
        above_ok  = 1'b0;
        above_idx = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ptr_q == PTRW'(i)) begin
                cur_ok = LCT_MASK[i];
            end
            if (!low_ok && LCT_MASK[i]) begin
                low_ok  = 1'b1;
                low_idx = PTRW'(i);
            end
        end
        sel = cur_ok ? ptr_q : low_idx;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!above_ok && LCT_MASK[i] && (PTRW'(i) > sel)) begin
                above_ok  = 1'b1;
                above_idx = PTRW'(i);
            end
        end
        nxt   = above_ok ? above_idx : low_idx;
        lct_d = '0;
        ptr_d = ptr_q;
        if (fire && low_ok) begin
            lct_d = NCH'(1) << sel;
            ptr_d = nxt;
        end
    end

    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            tgl_q   <= 1'b0;
            go_q    <= 1'b0;
            run_q   <= 1'b0;
            mode_q  <= TRG_OFF;
            pcnt_q  <= '0;
            state_q <= BST_IDLE;
            rem_q   <= '0;
            dead_q  <= '0;
            ptr_q   <= '0;
            trg_q   <= 1'b0;
            lct_q   <= '0;
            cnt_q   <= '0;
        end else begin
            tgl_q   <= RTRG_TGL;
            go_q    <= BURST_GO;
            run_q   <= run_d;
            mode_q  <= mode;
            pcnt_q  <= pcnt_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            dead_q  <= dead_d;
            ptr_q   <= ptr_d;
            trg_q   <= trg_d;
            lct_q   <= lct_d;
            cnt_q   <= cnt_d;
        end
    end

    assign TRG     = trg_q;
    assign LCT     = lct_q;
    assign RUN     = run_q;
    assign BUSY    = (state_q == BST_BURST);
    assign TRG_CNT = cnt_q;

endmodule

// File: tb/tb_trg_pattern_gen.sv
// Directed bench for trg_pattern_gen; a second CW=4 instance exercises count saturation.
module tb_trg_pattern_gen;

`ifdef TRG_DEADTIME_EN
    localparam int SP = 5;
`else
    localparam int SP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [15:0] period = 16'd10;
    logic [15:0] thresh = 16'd0;
    logic        tgl = 1'b0;
    logic [7:0]  burst_n = 8'd0;
    logic        burst_go = 1'b0;
    logic [5:0]  lct_mask = 6'h3F;
    logic        cnt_clr = 1'b0;
    logic        cnt_clr2 = 1'b0;

    logic        trg, run, busy, trg2, run2, busy2;
    logic [5:0]  lct, lct2;
    logic [23:0] trg_cnt;
    logic [3:0]  trg_cnt2;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    trg_pattern_gen #(.NCH(6), .PW(16), .LW(16), .BW(8), .CW(24), .DEADTIME(4)) dut (
        .CLKCMS(clk), .RST(rst), .MODE(mode), .PERIOD(period), .THRESH(thresh),
        .RTRG_TGL(tgl), .BURST_N(burst_n), .BURST_GO(burst_go), .LCT_MASK(lct_mask),
        .CNT_CLR(cnt_clr), .TRG(trg), .LCT(lct), .RUN(run), .BUSY(busy), .TRG_CNT(trg_cnt)
    );

    trg_pattern_gen #(.NCH(6), .PW(16), .LW(16), .BW(8), .CW(4), .DEADTIME(4)) dut_sat (
        .CLKCMS(clk), .RST(rst), .MODE(mode), .PERIOD(period), .THRESH(thresh),
        .RTRG_TGL(tgl), .BURST_N(burst_n), .BURST_GO(burst_go), .LCT_MASK(lct_mask),
        .CNT_CLR(cnt_clr2), .TRG(trg2), .LCT(lct2), .RUN(run2), .BUSY(busy2), .TRG_CNT(trg_cnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int n_trg, n_busy, n_exp_busy;
        logic [5:0] lct_seq [5];
        lct_seq = '{6'h01, 6'h08, 6'h20, 6'h01, 6'h08};

        tick();
        tick();
        check_eq("rst_trg", trg, 0);
        check_eq("rst_lct", lct, 0);
        check_eq("rst_run", run, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cnt", trg_cnt, 0);
        rst = 1'b0;
        tick();

        // Periodic, PERIOD=10: TRG at 11,21,31 relative to tick where RUN goes high
        mode = 2'd1;
        period = 16'd10;
        tgl = 1'b1;
        for (int m = 1; m <= 60; m++) begin
            tick();
            if (m == 1) begin
                check_eq("per_run_on", run, 1);
                tgl = 1'b0;
            end
            check_eq("per_trg", trg, (m > 1 && (m - 1) % 10 == 0 && m <= 36) ? 1 : 0);
            if (m == 35) tgl = 1'b1;
            if (m == 36) tgl = 1'b0;
            if (m == 40) check_eq("per_run_off", run, 0);
        end
        check_eq("per_cnt", trg_cnt, 3);
        check_eq("per_cnt_sat4", trg_cnt2, 3);
        mode = 2'd0;

        // Burst of 5 with mask 101001 from a fresh pointer
        do_reset();
        lct_mask = 6'b101001;
        burst_n = 8'd5;
        burst_go = 1'b1;
        n_busy = 0;
        for (int m = 1; m <= 5 * SP + 6; m++) begin
            logic e_trg;
            tick();
            if (m == 1) burst_go = 1'b0;
            e_trg = (m >= 2 && (m - 2) % SP == 0 && (m - 2) / SP < 5);
            check_eq("bst_trg", trg, e_trg);
            check_eq("bst_lct", lct, e_trg ? lct_seq[(m - 2) / SP] : 6'h00);
            check_eq("bst_busy", busy, (m >= 1 && m <= 1 + 4 * SP) ? 1 : 0);
            if (busy) n_busy++;
        end
        check_eq("bst_busy_len", n_busy, 1 + 4 * SP);
        check_eq("bst_cnt", trg_cnt, 5);

        // BURST_GO edge while busy is ignored; held level does not restart
        burst_n = 8'd4;
        burst_go = 1'b1;
        n_busy = 0;
        n_trg = 0;
        for (int m = 1; m <= 3 * SP + 15; m++) begin
            tick();
            if (m == 1) burst_go = 1'b0;
            if (m == 2) burst_go = 1'b1;
            if (busy) n_busy++;
            if (trg) n_trg++;
        end
        burst_go = 1'b0;
        check_eq("col_busy_len", n_busy, 1 + 3 * SP);
        check_eq("col_trg_n", n_trg, 4);
        check_eq("col_cnt", trg_cnt, 9);

`ifndef TRG_DEADTIME_EN
        // Periodic PERIOD=2 overlapping a 4-trigger burst; dropped fires are not queued
        tick();
        mode = 2'd1;
        period = 16'd2;
        tgl = 1'b1;
        for (int m = 1; m <= 24; m++) begin
            tick();
            if (m == 1) tgl = 1'b0;
            check_eq("mix_trg", trg, ((m >= 3 && m % 2 == 1) || (m >= 12 && m <= 15)) ? 1 : 0);
            check_eq("mix_busy", busy, (m >= 11 && m <= 14) ? 1 : 0);
            if (m == 10) burst_go = 1'b1;
            if (m == 11) burst_go = 1'b0;
        end
        tgl = 1'b1;
        tick();
        tgl = 1'b0;
        mode = 2'd0;
        tick();
`endif

        // Reset asserted during the 3rd of 8 burst triggers
        do_reset();
        lct_mask = 6'h3F;
        burst_n = 8'd8;
        burst_go = 1'b1;
        for (int m = 1; m <= 2 + 2 * SP; m++) begin
            tick();
            if (m == 1) burst_go = 1'b0;
        end
        check_eq("mid_trg3", trg, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_trg", trg, 0);
        check_eq("mid_rst_lct", lct, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_cnt", trg_cnt, 0);
        tick();
        tick();
        rst = 1'b0;
        n_trg = 0;
        n_busy = 0;
        for (int m = 0; m < 30; m++) begin
            tick();
            if (trg) n_trg++;
            if (busy) n_busy++;
        end
        check_eq("mid_post_trg", n_trg, 0);
        check_eq("mid_post_busy", n_busy, 0);

        // CNT_CLR beats a simultaneous increment; empty mask still triggers with LCT=0
        burst_n = 8'd3;
        burst_go = 1'b1;
        for (int m = 1; m <= 3 * SP + 5; m++) begin
            tick();
            burst_go = 1'b0;
        end
        check_eq("clr_pre_cnt", trg_cnt, 3);
        lct_mask = 6'h00;
        burst_n = 8'd2;
        burst_go = 1'b1;
        tick();
        burst_go = 1'b0;
        check_eq("clr_busy", busy, 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_eq("clr_trg", trg, 1);
        check_eq("clr_lct0", lct, 0);
        check_eq("clr_win", trg_cnt, 0);
        for (int m = 0; m < SP + 2; m++) tick();
        check_eq("clr_after", trg_cnt, 1);

        // Random, THRESH=0x4000, one full LFSR period: 16383 of 65535 states lie below
        do_reset();
        lct_mask = 6'h3F;
        mode = 2'd2;
        thresh = 16'h4000;
        tgl = 1'b1;
        tick();
        tgl = 1'b0;
        check_eq("rnd_run", run, 1);
        n_trg = 0;
        for (int m = 0; m < 65535; m++) begin
            tick();
            if (trg) n_trg++;
        end
`ifdef TRG_DEADTIME_EN
        check_eq("rnd_band", (n_trg > 1000 && n_trg < 16383) ? 1 : 0, 1);
`else
        check_eq("rnd_count", n_trg, 16383);
`endif
        check_eq("rnd_cnt_reg", trg_cnt, n_trg);
        check_eq("sat_cnt", trg_cnt2, 15);
        tgl = 1'b1;
        tick();
        tgl = 1'b0;
        thresh = 16'h0000;
        for (int m = 0; m < 10; m++) tick();
        check_eq("rnd_off", run, 0);
        tgl = 1'b1;
        tick();
        tgl = 1'b0;
        n_trg = 0;
        for (int m = 0; m < 300; m++) begin
            tick();
            if (trg) n_trg++;
        end
        check_eq("rnd_thr0", n_trg, 0);
        check_eq("sat_hold", trg_cnt2, 15);

        n_exp_busy = 0;
        check_eq("end_busy", busy, n_exp_busy);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
